stream_arg_extremum: RTL and testbench

- Streaming arg-max / arg-min engine over framed input: consumes one sample per accepted beat and reports the index and value of the extreme sample once the frame's last beat is accepted.
- Valid/ready on both sides; per-frame max/min mode; signedness chosen at elaboration.
- Sits after feature/score pipelines (e.g. classifier logits) and feeds decision logic.

---
 rtl/stream_arg_extremum_pkg.sv | 14 +
 rtl/stream_arg_extremum_arg_compare.sv | 40 ++++
 rtl/stream_arg_extremum.sv | 160 ++++++++++++++++
 tb/tb_stream_arg_extremum.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arg_extremum_pkg.sv
// Shared definitions for the streaming arg-max / arg-min engine.
//   MODE_MAX / MODE_MIN : encoding of the per-frame compare direction.
//   state_t             : frame-tracking FSM encoding (IDLE, ACCUM).
package stream_arg_extremum_pkg;

   localparam logic MODE_MAX = 1'b0;
   localparam logic MODE_MIN = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

endpackage

// File: rtl/stream_arg_extremum_arg_compare.sv
// Combinational "strictly better" comparator.
//   a, b      : candidate and incumbent samples (WIDTH bits).
//   mode_min  : MODE_MAX -> better = a > b, MODE_MIN -> better = a < b.
//   better    : a strictly beats b; ties report 0 so the earlier sample wins.
// SIGNED != 0 selects two's-complement compare, otherwise unsigned.
module arg_compare
   import stream_arg_extremum_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode_min,
   output logic             better
);

   logic w_gt;
   logic w_lt;

   generate
      if (SIGNED != 0) begin : g_signed
         assign w_gt = $signed(a) > $signed(b);
         assign w_lt = $signed(a) < $signed(b);
      end else begin : g_unsigned
         assign w_gt = a > b;
         assign w_lt = a < b;
      end
   endgenerate

   always_comb begin
      better = 1'b0;
      if (mode_min == MODE_MIN) begin
         better = w_lt;
      end else if (mode_min == MODE_MAX) begin
         better = w_gt;
      end
   end

endmodule

// File: rtl/stream_arg_extremum.sv
// Streaming arg-max / arg-min over framed input.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset.
//   in_valid/ready  : sample beat handshake; in_data sample, in_last ends frame,
//                     in_mode_min (0 max, 1 min) sampled on the first beat only.
//   out_valid/ready : result handshake; out_index/out_value give the extreme
//                     sample, out_overflow flags a frame longer than 2**INDEX_WIDTH.
//   dbg_state       : current FSM state (IDLE=0, ACCUM=1) for observation.
// Handshakes: a beat or result transfers on a rising edge where valid && ready
// are both high. valid does not depend on ready; once a result is raised it
// stays stable until taken. in_ready is low only while a result is held
// un-taken, so a new last beat and the old result can transfer on the same edge.
module stream_arg_extremum
   import stream_arg_extremum_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int INDEX_WIDTH = 3,
   parameter int SIGNED      = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_last,
   input  logic                   in_mode_min,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INDEX_WIDTH-1:0] out_index,
   output logic [WIDTH-1:0]       out_value,
   output logic                   out_overflow,
   output logic                   dbg_state
);

   localparam logic [INDEX_WIDTH:0] POS_ONE = {{INDEX_WIDTH{1'b0}}, 1'b1};

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WIDTH-1:0]       r_best_val;
   logic [WIDTH-1:0]       w_best_val_nxt;
   logic [INDEX_WIDTH-1:0] r_best_idx;
   logic [INDEX_WIDTH-1:0] w_best_idx_nxt;
   logic                   r_mode;
   logic                   w_mode_nxt;
   logic [INDEX_WIDTH:0]   r_pos;
   logic [INDEX_WIDTH:0]   w_pos_nxt;
   logic                   r_ovf;
   logic                   w_ovf_nxt;

   logic                   r_out_valid;
   logic [INDEX_WIDTH-1:0] r_out_index;
   logic [WIDTH-1:0]       r_out_value;
   logic                   r_out_overflow;

   logic                   w_accept;
   logic                   w_emit;
   logic                   w_better;

   assign in_ready     = !(r_out_valid && !out_ready);
   assign w_accept     = in_valid && in_ready;
   assign w_emit       = w_accept && in_last;
   assign out_valid    = r_out_valid;
   assign out_index    = r_out_index;
   assign out_value    = r_out_value;
   assign out_overflow = r_out_overflow;
   assign dbg_state    = r_state;

   arg_compare #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_cmp (
      .a        (in_data),
      .b        (r_best_val),
      .mode_min (r_mode),
      .better   (w_better)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_best_val_nxt = r_best_val;
      w_best_idx_nxt = r_best_idx;
      w_mode_nxt     = r_mode;
      w_pos_nxt      = r_pos;
      w_ovf_nxt      = r_ovf;
      if (w_accept) begin
         case (r_state)
            IDLE: begin
               // First sample loads unconditionally: no sentinel value needed.
               w_best_val_nxt = in_data;
               w_best_idx_nxt = '0;
               w_mode_nxt     = in_mode_min;
               w_pos_nxt      = POS_ONE;
               w_ovf_nxt      = 1'b0;
               if (!in_last) begin
                  w_state_nxt = ACCUM;
               end
            end
            ACCUM: begin
               // pos saturates at exactly 2**INDEX_WIDTH, so its top bit alone
               // tells whether the frame still fits.
               if (!r_pos[INDEX_WIDTH]) begin
                  if (w_better) begin
                     w_best_val_nxt = in_data;
                     w_best_idx_nxt = r_pos[INDEX_WIDTH-1:0];
                  end
                  w_pos_nxt = r_pos + POS_ONE;
               end else begin
                  w_ovf_nxt = 1'b1;
               end
               if (in_last) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_best_val <= '0;
         r_best_idx <= '0;
         r_mode     <= MODE_MAX;
         r_pos      <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_best_val <= w_best_val_nxt;
         r_best_idx <= w_best_idx_nxt;
         r_mode     <= w_mode_nxt;
         r_pos      <= w_pos_nxt;
         r_ovf      <= w_ovf_nxt;
      end
   end

   // Result register: loads from the updated best so the last sample counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid    <= 1'b0;
         r_out_index    <= '0;
         r_out_value    <= '0;
         r_out_overflow <= 1'b0;
      end else if (w_emit) begin
         r_out_valid    <= 1'b1;
         r_out_index    <= w_best_idx_nxt;
         r_out_value    <= w_best_val_nxt;
         r_out_overflow <= w_ovf_nxt;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_arg_extremum.sv
// Bench for stream_arg_extremum: a signed and an unsigned instance share the
// same input stream; each has its own expected-result queue fed by a
// reference model when a frame is driven.
module tb_stream_arg_extremum;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_mode_min;
   logic       out_ready;

   logic       s_in_ready, s_out_valid, s_out_overflow, s_dbg_state;
   logic [2:0] s_out_index;
   logic [7:0] s_out_value;
   logic       u_in_ready, u_out_valid, u_out_overflow, u_dbg_state;
   logic [2:0] u_out_index;
   logic [7:0] u_out_value;

   logic [11:0] exp_s_q[$];
   logic [11:0] exp_u_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   stream_arg_extremum #(.WIDTH(8), .INDEX_WIDTH(3), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .in_last(in_last), .in_mode_min(in_mode_min),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_index(s_out_index), .out_value(s_out_value),
      .out_overflow(s_out_overflow), .dbg_state(s_dbg_state)
   );

   stream_arg_extremum #(.WIDTH(8), .INDEX_WIDTH(3), .SIGNED(0)) dut_u (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
      .in_last(in_last), .in_mode_min(in_mode_min),
      .out_valid(u_out_valid), .out_ready(out_ready),
      .out_index(u_out_index), .out_value(u_out_value),
      .out_overflow(u_out_overflow), .dbg_state(u_dbg_state)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference model: returns {ovf, idx[2:0], val[7:0]}.
   function automatic logic [11:0] model(input logic [7:0] smp[$], input bit mode_min, input bit sgn);
      int best, v, bidx;
      bit ovf;
      best = sgn ? int'($signed(smp[0])) : int'(smp[0]);
      bidx = 0;
      ovf  = 1'b0;
      for (int i = 1; i < smp.size(); i++) begin
         if (i >= 8) begin
            ovf = 1'b1;
         end else begin
            v = sgn ? int'($signed(smp[i])) : int'(smp[i]);
            if ((mode_min && v < best) || (!mode_min && v > best)) begin
               best = v;
               bidx = i;
            end
         end
      end
      return {ovf, 3'(bidx), 8'(best)};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [11:0] e;
      if (!rst && s_out_valid && out_ready) begin
         if (exp_s_q.size() == 0) begin
            check("s_unexpected_result", s_out_valid, 1'b0);
         end else begin
            e = exp_s_q.pop_front();
            check("s_out_index", s_out_index, e[10:8]);
            check("s_out_value", s_out_value, e[7:0]);
            check("s_out_overflow", s_out_overflow, e[11]);
         end
      end
      if (!rst && u_out_valid && out_ready) begin
         if (exp_u_q.size() == 0) begin
            check("u_unexpected_result", u_out_valid, 1'b0);
         end else begin
            e = exp_u_q.pop_front();
            check("u_out_index", u_out_index, e[10:8]);
            check("u_out_value", u_out_value, e[7:0]);
            check("u_out_overflow", u_out_overflow, e[11]);
         end
      end
   end

   // ---------------- driver ----------------
   // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
   task automatic send_frame(input logic [7:0] smp[$], input bit mode, input bit mid_mode,
                             input bit hold_valid);
      int n;
      exp_s_q.push_back(model(smp, mode, 1'b1));
      exp_u_q.push_back(model(smp, mode, 1'b0));
      for (int i = 0; i < smp.size(); i++) begin
         in_valid    = 1'b1;
         in_data     = smp[i];
         in_last     = (i == smp.size() - 1);
         in_mode_min = (i == 0) ? mode : mid_mode;
         n = 0;
         @(negedge clk);
         while (!s_in_ready && n < 64) begin
            @(negedge clk);
            n++;
         end
         if (!s_in_ready) check("accept_timeout", s_in_ready, 1'b1);
         @(posedge clk);
         #1;
      end
      if (!hold_valid) begin
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] f[$];
      int n;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      in_mode_min = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset_out_valid", s_out_valid, 1'b0);
      check("reset_out_index", s_out_index, 3'd0);
      check("reset_out_value", s_out_value, 8'd0);
      check("reset_out_overflow", s_out_overflow, 1'b0);
      check("reset_in_ready", s_in_ready, 1'b1);
      check("reset_state_idle", s_dbg_state, 1'b0);
      @(posedge clk); #1;

      // Max with tie: expect index 2 value 7, one cycle after the last beat.
      f = '{8'd3, 8'hFB, 8'd7, 8'd7, 8'd2};
      send_frame(f, 1'b0, 1'b0, 1'b0);
      check("latency_out_valid", s_out_valid, 1'b1);
      check("tie_index_direct", s_out_index, 3'd2);
      check("tie_value_direct", s_out_value, 8'd7);
      @(posedge clk); #1;

      // Min latched on first beat, mode toggled mid-frame: index 1 value -5.
      send_frame(f, 1'b1, 1'b0, 1'b0);
      check("min_index_direct", s_out_index, 3'd1);
      check("min_value_direct", s_out_value, 8'hFB);
      @(posedge clk); #1;

      // All most-negative samples.
      f = '{8'h80, 8'h80, 8'h80};
      send_frame(f, 1'b0, 1'b0, 1'b0);
      check("neg_sentinel_value", s_out_value, 8'h80);
      check("neg_sentinel_index", s_out_index, 3'd0);
      @(posedge clk); #1;

      // Signedness split: unsigned picks 0x80 at index 0.
      f = '{8'h80, 8'h7F};
      send_frame(f, 1'b0, 1'b0, 1'b0);
      check("unsigned_index", u_out_index, 3'd0);
      check("unsigned_value", u_out_value, 8'h80);
      @(posedge clk); #1;

      // Exactly full frame: max at the last allowed slot, no overflow.
      f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      send_frame(f, 1'b0, 1'b0, 1'b0);
      check("full_frame_index", s_out_index, 3'd7);
      check("full_frame_overflow", s_out_overflow, 1'b0);
      @(posedge clk); #1;

      // Overflow: 10 samples, 99 at positions 2 and 9.
      f = '{8'd1, 8'd5, 8'd99, 8'd4, 8'd0, 8'd7, 8'd3, 8'd2, 8'd6, 8'd99};
      send_frame(f, 1'b0, 1'b0, 1'b0);
      check("ovf_index", s_out_index, 3'd2);
      check("ovf_value", s_out_value, 8'd99);
      check("ovf_flag", s_out_overflow, 1'b1);
      @(posedge clk); #1;

      // Backpressure: result A held four cycles while frame B waits.
      out_ready = 1'b0;
      f = '{8'd4, 8'd9, 8'd1};
      send_frame(f, 1'b0, 1'b0, 1'b0);
      check("bp_a_valid", s_out_valid, 1'b1);
      f = '{8'hF0};
      exp_s_q.push_back(model(f, 1'b0, 1'b1));
      exp_u_q.push_back(model(f, 1'b0, 1'b0));
      in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b1; in_mode_min = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_in_ready_low", s_in_ready, 1'b0);
         check("bp_hold_valid", s_out_valid, 1'b1);
         check("bp_hold_index", s_out_index, 3'd1);
         check("bp_hold_value", s_out_value, 8'd9);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", s_in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      check("bp_b_valid", s_out_valid, 1'b1);
      check("bp_b_value", s_out_value, 8'hF0);
      @(posedge clk); #1;

      // Back-to-back single-sample frames: a result every cycle.
      for (int i = 0; i < 5; i++) begin
         f = '{8'($urandom_range(0, 255))};
         send_frame(f, 1'($urandom_range(0, 1)), 1'b0, (i != 4));
         check("b2b_out_valid", s_out_valid, 1'b1);
      end
      @(posedge clk); #1;

      // Random frames, lengths spanning the overflow boundary.
      for (int k = 0; k < 6; k++) begin
         f = {};
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(0, 255)));
         send_frame(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end
      repeat (2) @(posedge clk); #1;

      // Reset during output hold: result discarded, outputs clear at once.
      out_ready = 1'b0;
      f = '{8'h11, 8'h22};
      send_frame(f, 1'b0, 1'b0, 1'b0);
      check("hold_before_reset", s_out_valid, 1'b1);
      #3 rst = 1'b1;
      #1;
      check("rst_hold_out_valid", s_out_valid, 1'b0);
      check("rst_hold_out_index", s_out_index, 3'd0);
      check("rst_hold_out_value", s_out_value, 8'd0);
      check("rst_hold_out_overflow", s_out_overflow, 1'b0);
      check("rst_hold_u_out_valid", u_out_valid, 1'b0);
      exp_s_q.delete();
      exp_u_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Reset mid-ACCUM with a large partial best, then an unrelated frame.
      in_valid = 1'b1; in_data = 8'd100; in_last = 1'b0; in_mode_min = 1'b0;
      @(posedge clk); #1;
      in_data = 8'd50;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("accum_before_reset", s_dbg_state, 1'b1);
      #3 rst = 1'b1;
      #1;
      check("rst_accum_state", s_dbg_state, 1'b0);
      check("rst_accum_out_valid", s_out_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      f = '{8'd10, 8'd20};
      send_frame(f, 1'b0, 1'b0, 1'b0);
      check("post_reset_index", s_out_index, 3'd1);
      check("post_reset_value", s_out_value, 8'd20);

      // Drain the scoreboard.
      n = 0;
      while ((exp_s_q.size() != 0 || exp_u_q.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_s_queue", exp_s_q.size(), 0);
      check("drain_u_queue", exp_u_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
